lsu_wb: RTL and testbench

- Writeback stage directly upstream of the register file; sole driver of the RF write port (wen/waddr/wdata).
- ALU results: registered and written one cycle after acceptance.
- Loads: issues one memory read over a valid/ready request channel, waits for the response, extracts and sign- or zero-extends the loaded value, then writes it back.
- Rejects misaligned and illegal loads with an error pulse and no write.

---
 rtl/lsu_wb_pkg.sv | 32 +++
 rtl/lsu_wb_load_align.sv | 34 +++
 rtl/lsu_wb.sv | 150 +++++++++++++++
 tb/tb_lsu_wb.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_wb_pkg.sv
// Shared types and constants for the lsu_wb writeback stage.
package lsu_wb_pkg;

    localparam int unsigned LSU_ADDR_WIDTH = 5;
    localparam int unsigned LSU_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Misaligned halfword/word or reserved funct3 encoding.
    function automatic logic load_illegal(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3)
            F3_LB, F3_LBU: bad = 1'b0;
            F3_LH, F3_LHU: bad = lo[0];
            F3_LW:         bad = (lo != 2'b00);
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_wb_load_align.sv
// Lane select and sign/zero extension of a loaded memory word.
module load_align
    import lsu_wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = LSU_DATA_WIDTH
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0] data
);

    logic [4:0]  w_byte_sel;
    logic [4:0]  w_half_sel;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte_sel = {addr_lo, 3'b000};
    assign w_half_sel = {addr_lo[1], 4'b0000};
    assign w_byte     = word[w_byte_sel +: 8];
    assign w_half     = word[w_half_sel +: 16];

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            F3_LH:   data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/lsu_wb.sv
// Writeback stage: registers ALU results, performs single-outstanding loads,
// and is the sole driver of the register-file write port.
module lsu_wb
    import lsu_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = LSU_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = LSU_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [DATA_WIDTH-1:0] in_addr,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  ld_err,
    output logic                  busy
);

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_rd;
    logic [2:0]            r_funct3;
    logic [1:0]            r_addr_lo;
    logic [DATA_WIDTH-1:0] r_req_addr;
    logic                  r_rf_wen;
    logic [ADDR_WIDTH-1:0] r_rf_waddr;
    logic [DATA_WIDTH-1:0] r_rf_wdata;
    logic                  r_ld_err;

    logic                  w_accept;
    logic                  w_lat_load;
    logic                  w_rf_wen_next;
    logic [ADDR_WIDTH-1:0] w_rf_waddr_next;
    logic [DATA_WIDTH-1:0] w_rf_wdata_next;
    logic                  w_ld_err_next;
    logic [DATA_WIDTH-1:0] w_load_data;

    assign in_ready      = (r_state == ST_IDLE) || (r_state == ST_WB);
    assign busy          = (r_state != ST_IDLE);
    assign mem_req_valid = (r_state == ST_REQ);
    assign mem_req_addr  = r_req_addr;
    assign rf_wen        = r_rf_wen;
    assign rf_waddr      = r_rf_waddr;
    assign rf_wdata      = r_rf_wdata;
    assign ld_err        = r_ld_err;
    assign w_accept      = in_valid && in_ready;

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .funct3  (r_funct3),
        .addr_lo (r_addr_lo),
        .word    (mem_resp_data),
        .data    (w_load_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and next values of the write port / error pulse.
    always_comb begin
        w_state_next    = r_state;
        w_lat_load      = 1'b0;
        w_rf_wen_next   = 1'b0;
        w_rf_waddr_next = r_rf_waddr;
        w_rf_wdata_next = r_rf_wdata;
        w_ld_err_next   = 1'b0;
        case (r_state)
            ST_IDLE, ST_WB: begin
                w_state_next = ST_IDLE;
                if (w_accept) begin
                    if (in_is_load) begin
                        if (load_illegal(in_funct3, in_addr[1:0])) begin
                            w_ld_err_next = 1'b1;
                        end else begin
                            w_lat_load   = 1'b1;
                            w_state_next = ST_REQ;
                        end
                    end else begin
                        w_state_next = ST_WB;
                        // x0 is never written; the op still flows through WB.
                        if (in_rd != '0) begin
                            w_rf_wen_next   = 1'b1;
                            w_rf_waddr_next = in_rd;
                            w_rf_wdata_next = in_result;
                        end
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    w_state_next = ST_WB;
                    if (r_rd != '0) begin
                        w_rf_wen_next   = 1'b1;
                        w_rf_waddr_next = r_rd;
                        w_rf_wdata_next = w_load_data;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Load context and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd       <= '0;
            r_funct3   <= '0;
            r_addr_lo  <= '0;
            r_req_addr <= '0;
            r_rf_wen   <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
            r_ld_err   <= 1'b0;
        end else begin
            if (w_lat_load) begin
                r_rd       <= in_rd;
                r_funct3   <= in_funct3;
                r_addr_lo  <= in_addr[1:0];
                r_req_addr <= {in_addr[DATA_WIDTH-1:2], 2'b00};
            end
            r_rf_wen   <= w_rf_wen_next;
            r_rf_waddr <= w_rf_waddr_next;
            r_rf_wdata <= w_rf_wdata_next;
            r_ld_err   <= w_ld_err_next;
        end
    end

endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb: stimulus tasks push expected RF writes and
// load errors into a scoreboard; a negedge monitor pops and compares them.
module tb_lsu_wb;
    import lsu_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ld_err;
    logic        busy;

    lsu_wb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rd          (in_rd),
        .in_result      (in_result),
        .in_is_load     (in_is_load),
        .in_funct3      (in_funct3),
        .in_addr        (in_addr),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .rf_wen         (rf_wen),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .ld_err         (ld_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every RF write or load error must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_wen) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got waddr=%0d wdata=0x%08h expected no write", rf_waddr, rf_wdata);
                end else begin
                    mon_e = sb.pop_front();
                    check("wr_kind", 32'(ld_err), 32'(mon_e.is_err));
                    check("wr_waddr", 32'(rf_waddr), 32'(mon_e.waddr));
                    check("wr_wdata", rf_wdata, mon_e.wdata);
                    check("wr_cycle", cyc, mon_e.cyc);
                end
            end
            if (ld_err) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ld_err: got 1 expected 0");
                end else begin
                    mon_e = sb.pop_front();
                    check("err_kind", 32'(mon_e.is_err), 32'(1));
                    check("err_cycle", cyc, mon_e.cyc);
                end
            end
        end
    end

    // Returns at the negedge before the accepting posedge.
    task automatic wait_accept();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    endtask

    task automatic send_alu(input logic [4:0] rd, input logic [31:0] res);
        in_valid   = 1'b1;
        in_is_load = 1'b0;
        in_rd      = rd;
        in_result  = res;
        in_funct3  = 3'b000;
        in_addr    = 32'h0;
        wait_accept();
        if (rd != 5'd0) sb.push_back('{1'b0, rd, res, cyc + 1});
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (rd == 5'd0) begin
            @(negedge clk);
            check("rd0_no_wen", 32'(rf_wen), 32'(0));
            check("rd0_busy_wb", 32'(busy), 32'(1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] resp, input int req_stall, input int resp_delay,
                             input logic [31:0] exp_data, input bit exp_err);
        logic [31:0] exp_addr;
        exp_addr   = {addr[31:2], 2'b00};
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = rd;
        in_funct3  = f3;
        in_addr    = addr;
        in_result  = 32'h5A5A_5A5A;
        wait_accept();
        if (exp_err) sb.push_back('{1'b1, 5'd0, 32'h0, cyc + 1});
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_is_load = 1'b0;
        if (exp_err) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("err_no_req", 32'(mem_req_valid), 32'(0));
                check("err_not_busy", 32'(busy), 32'(0));
            end
            @(posedge clk);
            #1;
            return;
        end
        for (int i = 0; i < req_stall; i++) begin
            @(negedge clk);
            check("req_valid_stall", 32'(mem_req_valid), 32'(1));
            check("req_addr_stall", mem_req_addr, exp_addr);
            @(posedge clk);
            #1;
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("req_valid", 32'(mem_req_valid), 32'(1));
        check("req_addr", mem_req_addr, exp_addr);
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        for (int i = 0; i < resp_delay; i++) begin
            @(negedge clk);
            check("wait_no_req", 32'(mem_req_valid), 32'(0));
            @(posedge clk);
            #1;
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = resp;
        @(negedge clk);
        if (rd != 5'd0) sb.push_back('{1'b0, rd, exp_data, cyc + 1});
        @(posedge clk);
        #1 mem_resp_valid = 1'b0;
        mem_resp_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check("load_wen_pulse", 32'(rf_wen), 32'(rd != 5'd0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_rd          = 5'd0;
        in_result      = 32'h0;
        in_is_load     = 1'b0;
        in_funct3      = 3'b000;
        in_addr        = 32'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_wen", 32'(rf_wen), 32'(0));
        check("rst_waddr", 32'(rf_waddr), 32'(0));
        check("rst_wdata", rf_wdata, 32'h0);
        check("rst_req_valid", 32'(mem_req_valid), 32'(0));
        check("rst_ld_err", 32'(ld_err), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ALU op, then confirm the pulse is one cycle with held data.
        send_alu(5'd5, 32'h1234_5678);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("alu_wen_single", 32'(rf_wen), 32'(0));
        check("alu_waddr_hold", 32'(rf_waddr), 32'(5));
        check("alu_wdata_hold", rf_wdata, 32'h1234_5678);
        @(posedge clk);
        #1;

        // Back-to-back ALU ops: scoreboard cycle stamps demand consecutive writes.
        send_alu(5'd1, 32'hAAAA_0001);
        send_alu(5'd2, 32'hBBBB_0002);
        send_alu(5'd3, 32'hCCCC_0003);
        repeat (2) @(posedge clk);
        #1;

        // Loads: byte/half lanes, extension, request stall and response delay.
        send_load(5'd7,  F3_LB,  32'h8000_0003, 32'h80FF_0000, 0, 1, 32'hFFFF_FF80, 1'b0);
        send_load(5'd8,  F3_LBU, 32'h8000_0003, 32'h80FF_0000, 0, 0, 32'h0000_0080, 1'b0);
        send_load(5'd9,  F3_LH,  32'h8000_0012, 32'h8001_7FFF, 3, 4, 32'hFFFF_8001, 1'b0);
        send_load(5'd10, F3_LHU, 32'h0000_0100, 32'h1234_F00D, 1, 2, 32'h0000_F00D, 1'b0);
        send_load(5'd11, F3_LW,  32'h0000_0200, 32'hCAFE_BABE, 0, 0, 32'hCAFE_BABE, 1'b0);
        send_load(5'd12, F3_LB,  32'h0000_0041, 32'h1122_3344, 0, 0, 32'h0000_0033, 1'b0);

        // Illegal / misaligned loads.
        send_load(5'd4, F3_LW,  32'h0000_0301, 32'h0, 0, 0, 32'h0, 1'b1);
        send_load(5'd4, 3'b011, 32'h0000_0300, 32'h0, 0, 0, 32'h0, 1'b1);
        send_load(5'd4, F3_LHU, 32'h0000_0303, 32'h0, 0, 0, 32'h0, 1'b1);

        // Write to x0 is suppressed.
        send_alu(5'd0, 32'hDEAD_BEEF);
        check("rd0_waddr_hold", 32'(rf_waddr), 32'(12));

        // Reset while waiting for a response.
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_rd      = 5'd13;
        in_funct3  = F3_LW;
        in_addr    = 32'h0000_0400;
        wait_accept();
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_is_load = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1 mem_req_ready = 1'b0;
        @(negedge clk);
        check("wait_busy", 32'(busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check("midrst_wen", 32'(rf_wen), 32'(0));
        check("midrst_waddr", 32'(rf_waddr), 32'(0));
        check("midrst_wdata", rf_wdata, 32'h0);
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_req_valid", 32'(mem_req_valid), 32'(0));
        check("midrst_req_addr", mem_req_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 mem_resp_valid = 1'b1;
        mem_resp_data = 32'h7777_7777;
        @(posedge clk);
        #1 mem_resp_valid = 1'b0;
        @(negedge clk);
        check("late_resp_no_wen", 32'(rf_wen), 32'(0));
        check("late_resp_idle", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
        send_alu(5'd14, 32'h0BAD_F00D);
        repeat (3) @(posedge clk);
        #1;

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
